// File: rtl/gf_row_accum.sv
// Row accumulator for a GF(2^8) matrix-vector product: folds per-beat XOR-reduced
// lane products into row bytes and packs them MSB-first into PROC_SIZE-bit result words.
module gf_row_accum #(
    parameter int MAT_ROW_SIZE = 8,
    parameter int MAT_COL_SIZE = 8,
    parameter int N_GF         = 8,
    localparam int PROC_SIZE   = N_GF * 8,
    localparam int WORDS       = (MAT_ROW_SIZE + N_GF - 1) / N_GF,
    localparam int AW          = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_valid,
    input  logic [7:0]           i_partial,
    output logic                 o_ready,
    output logic [PROC_SIZE-1:0] o_res,
    output logic [AW-1:0]        o_res_addr,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int BEATS = MAT_COL_SIZE / N_GF;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = (N_GF > 1) ? $clog2(N_GF) : 1;
    localparam int RW    = $clog2(MAT_ROW_SIZE + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

    state_t               state, state_nx;
    logic [7:0]           acc;
    logic [7:0]           row_byte;
    logic [BW-1:0]        beat_cnt;
    logic [RW-1:0]        row_cnt;
    logic [LW-1:0]        lane_cnt;
    logic [PROC_SIZE-1:0] word_buf, word_nx;
    logic                 beat_fire, res_fire, row_done, last_row, word_done;

    assign o_busy    = (state != IDLE);
    assign o_done    = (state == DONE);
    assign o_ready   = (state == ACCUM) && !(o_res_valid && !i_res_ready);
    assign beat_fire = o_ready && i_valid;
    assign res_fire  = o_res_valid && i_res_ready;
    assign row_done  = beat_fire && (beat_cnt == BW'(BEATS - 1));
    assign last_row  = (row_cnt == RW'(MAT_ROW_SIZE - 1));
    assign word_done = row_done && ((lane_cnt == LW'(N_GF - 1)) || last_row);
    assign row_byte  = acc ^ i_partial;

    // Row byte k lands in lane k counted from the MSB end.
    always_comb begin
        word_nx = word_buf;
        word_nx[PROC_SIZE - 1 - 8 * int'(lane_cnt) -: 8] = row_byte;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start) state_nx = ACCUM;
            ACCUM:   if (row_done && last_row) state_nx = FLUSH;
            FLUSH:   if (res_fire) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc         <= '0;
            beat_cnt    <= '0;
            row_cnt     <= '0;
            lane_cnt    <= '0;
            word_buf    <= '0;
            o_res       <= '0;
            o_res_addr  <= '0;
            o_res_valid <= 1'b0;
        end else if (state == IDLE && i_start) begin
            acc        <= '0;
            beat_cnt   <= '0;
            row_cnt    <= '0;
            lane_cnt   <= '0;
            word_buf   <= '0;
            o_res_addr <= '0;
        end else begin
            if (res_fire) begin
                o_res_valid <= 1'b0;
                o_res_addr  <= o_res_addr + 1'b1;
            end
            // A completing word may load in the same cycle the previous one handshakes.
            if (beat_fire) begin
                if (row_done) begin
                    acc      <= '0;
                    beat_cnt <= '0;
                    row_cnt  <= row_cnt + 1'b1;
                    if (word_done) begin
                        o_res       <= word_nx;
                        o_res_valid <= 1'b1;
                        word_buf    <= '0;
                        lane_cnt    <= '0;
                    end else begin
                        word_buf <= word_nx;
                        lane_cnt <= lane_cnt + 1'b1;
                    end
                end else begin
                    acc      <= acc ^ i_partial;
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gf_row_accum.sv
// Bench for gf_row_accum: three parameterisations driven one at a time,
// results checked against a scoreboard of expected words.
module tb_gf_row_accum;

    typedef struct packed {
        logic [1:0]  inst;
        logic        addr;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          hs_cyc [3];
    exp_t        sb [$];
    exp_t        mon_e;

    logic [2:0]  rst_n, start, valid, res_ready;
    logic [7:0]  partial [3];
    logic [2:0]  ready, res_valid, busy, done, addr;
    logic [63:0] res_w [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    gf_row_accum #(.MAT_ROW_SIZE(8), .MAT_COL_SIZE(8), .N_GF(8)) u_dflt (
        .i_clk(clk), .i_rst(rst_n[0]), .i_start(start[0]), .i_valid(valid[0]),
        .i_partial(partial[0]), .o_ready(ready[0]), .o_res(res_w[0]),
        .o_res_addr(addr[0:0]), .o_res_valid(res_valid[0]), .i_res_ready(res_ready[0]),
        .o_busy(busy[0]), .o_done(done[0]));

    gf_row_accum #(.MAT_ROW_SIZE(8), .MAT_COL_SIZE(16), .N_GF(8)) u_col16 (
        .i_clk(clk), .i_rst(rst_n[1]), .i_start(start[1]), .i_valid(valid[1]),
        .i_partial(partial[1]), .o_ready(ready[1]), .o_res(res_w[1]),
        .o_res_addr(addr[1:1]), .o_res_valid(res_valid[1]), .i_res_ready(res_ready[1]),
        .o_busy(busy[1]), .o_done(done[1]));

    gf_row_accum #(.MAT_ROW_SIZE(10), .MAT_COL_SIZE(8), .N_GF(8)) u_row10 (
        .i_clk(clk), .i_rst(rst_n[2]), .i_start(start[2]), .i_valid(valid[2]),
        .i_partial(partial[2]), .o_ready(ready[2]), .o_res(res_w[2]),
        .o_res_addr(addr[2:2]), .o_res_valid(res_valid[2]), .i_res_ready(res_ready[2]),
        .o_busy(busy[2]), .o_done(done[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pops the expected word whenever a result handshake is about to happen.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n[k] && res_valid[k] && res_ready[k]) begin
                hs_cyc[k] = cyc;
                n_tests++;
                assert (sb.size() > 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected: inst %0d observed %h expected none", k, res_w[k]);
                end
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("res_inst", 64'(k), 64'(mon_e.inst));
                    check("res_word", res_w[k], mon_e.data);
                    check("res_addr", 64'(addr[k]), 64'(mon_e.addr));
                end
            end
        end
    end

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
    endtask

    task automatic beat(input int k, input logic [7:0] v);
        int t = 0;
        valid[k]   = 1'b1;
        partial[k] = v;
        @(negedge clk);
        while (!ready[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("beat_accepted", 64'(ready[k]), 64'd1);
        @(posedge clk); #1;
        valid[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int t = 0;
        @(negedge clk);
        while (!done[k] && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 64'(done[k]), 64'd1);
        check("done_latency", 64'(cyc), 64'(hs_cyc[k] + 1));
        check("busy_in_done", 64'(busy[k]), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(done[k]), 64'd0);
        check("idle_after_done", 64'(busy[k]), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset(input int k);
        check("rst_res", res_w[k], 64'd0);
        check("rst_addr", 64'(addr[k]), 64'd0);
        check("rst_res_valid", 64'(res_valid[k]), 64'd0);
        check("rst_ready", 64'(ready[k]), 64'd0);
        check("rst_busy", 64'(busy[k]), 64'd0);
        check("rst_done", 64'(done[k]), 64'd0);
    endtask

    initial begin
        rst_n = 3'b000; start = '0; valid = '0; res_ready = '0;
        for (int k = 0; k < 3; k++) begin
            partial[k] = 8'h00;
            hs_cyc[k]  = -10;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(2);
        rst_n = 3'b111;

        // Default geometry, consumer always ready.
        res_ready[0] = 1'b1;
        sb.push_back({2'd0, 1'b0, 64'h0102030405060708});
        pulse_start(0);
        check("busy_after_start", 64'(busy[0]), 64'd1);
        for (int i = 1; i <= 8; i++) beat(0, 8'(i));
        wait_done(0);

        // Two beats per row; 0x0F ^ 0xF0 fills every byte.
        res_ready[1] = 1'b1;
        sb.push_back({2'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF});
        pulse_start(1);
        for (int r = 0; r < 8; r++) begin
            beat(1, 8'h0F);
            beat(1, 8'hF0);
        end
        wait_done(1);

        // Ten rows: full first word held under backpressure, then a zero-filled second word.
        res_ready[2] = 1'b0;
        sb.push_back({2'd2, 1'b0, 64'h0102030405060708});
        sb.push_back({2'd2, 1'b1, 64'h090A000000000000});
        pulse_start(2);
        for (int i = 1; i <= 8; i++) beat(2, 8'(i));
        valid[2]   = 1'b1;
        partial[2] = 8'h09;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall_ready", 64'(ready[2]), 64'd0);
            check("stall_valid", 64'(res_valid[2]), 64'd1);
            check("stall_word", res_w[2], 64'h0102030405060708);
            check("stall_addr", 64'(addr[2]), 64'd0);
        end
        @(posedge clk); #1;
        res_ready[2] = 1'b1;
        beat(2, 8'h09);
        beat(2, 8'h0A);
        wait_done(2);

        // Reset mid-row, then beats without a start must be refused.
        pulse_start(0);
        for (int i = 1; i <= 3; i++) beat(0, 8'(i));
        rst_n[0] = 1'b0;
        #1;
        check_reset(0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        valid[0] = 1'b1;
        partial[0] = 8'h55;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("no_start_ready", 64'(ready[0]), 64'd0);
            check("no_start_busy", 64'(busy[0]), 64'd0);
        end
        @(posedge clk); #1;
        valid[0] = 1'b0;
        sb.push_back({2'd0, 1'b0, 64'h0102030405060708});
        pulse_start(0);
        for (int i = 1; i <= 8; i++) beat(0, 8'(i));
        wait_done(0);

        // Reset with a word pending clears the output register.
        res_ready[2] = 1'b0;
        pulse_start(2);
        for (int i = 1; i <= 8; i++) beat(2, 8'(i));
        check("pending_valid", 64'(res_valid[2]), 64'd1);
        rst_n[2] = 1'b0;
        #1;
        check_reset(2);
        @(posedge clk); #1;
        rst_n[2] = 1'b1;

        // A start pulse while accumulating must not disturb the run.
        sb.push_back({2'd0, 1'b0, 64'h0102030405060708});
        pulse_start(0);
        for (int i = 1; i <= 3; i++) beat(0, 8'(i));
        start[0] = 1'b1;
        beat(0, 8'h04);
        start[0] = 1'b0;
        for (int i = 5; i <= 8; i++) beat(0, 8'(i));
        wait_done(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gf_row_accum.md
GF_ROW_ACCUM -- requirements
Module: gf_row_accum

Interface
REQ-001 SHALL have parameter MAT_ROW_SIZE, default 8, meaning the number of matrix rows, equal to the result length in bytes.
REQ-002 SHALL have parameter MAT_COL_SIZE, default 8, meaning the number of matrix columns; it SHALL be a multiple of N_GF.
REQ-003 SHALL have parameter N_GF, default 8, meaning the GF(2^8) lanes per beat; PROC_SIZE = N_GF*8, BEATS = MAT_COL_SIZE/N_GF, WORDS = ceil(MAT_ROW_SIZE/N_GF).
REQ-004 SHALL have port i_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port i_start, input, 1 bit, a one-cycle request to begin a matrix-vector result.
REQ-007 SHALL have port i_valid, input, 1 bit, meaning i_partial carries one beat's XOR-reduced lane products.
REQ-008 SHALL have port i_partial, input, 8 bits, the GF(2^8) partial sum for one beat of the current row.
REQ-009 SHALL have port o_ready, output, 1 bit, meaning a beat is accepted this cycle when i_valid is also high.
REQ-010 SHALL have port o_res, output, PROC_SIZE bits, a packed result word.
REQ-011 SHALL have port o_res_addr, output, max(1,clog2(WORDS)) bits, the word index of o_res.
REQ-012 SHALL have port o_res_valid, output, 1 bit, meaning o_res/o_res_addr are valid.
REQ-013 SHALL have port i_res_ready, input, 1 bit, meaning the consumer accepts o_res when o_res_valid is also high.
REQ-014 SHALL have ports o_busy (1 bit, state not IDLE) and o_done (1 bit, completion pulse), both outputs.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, FLUSH, DONE.
REQ-016 SHALL move IDLE->ACCUM on i_start, clearing the accumulator, beat counter, row counter, byte-lane counter and word address.
REQ-017 SHALL ignore i_start in any state other than IDLE.
REQ-018 SHALL drive o_ready = (state==ACCUM) && !(o_res_valid && !i_res_ready).
REQ-019 SHALL, on each accepted beat, XOR i_partial into the 8-bit accumulator and increment the beat counter.
REQ-020 SHALL, on the accepted beat where the beat counter equals BEATS-1, form row byte = acc ^ i_partial, clear acc and the beat counter, and increment the row counter.
REQ-021 SHALL write row byte k of a word into bits [PROC_SIZE-8k-1 : PROC_SIZE-8k-8], so byte 0 is the MSB.
REQ-022 SHALL assert o_res_valid on the cycle after the edge that writes byte N_GF-1 of a word, or the byte of row MAT_ROW_SIZE-1.
REQ-023 SHALL zero-fill the unused lanes of a final partial word.
REQ-024 SHALL hold o_res, o_res_addr and o_res_valid stable until the handshake, then deassert o_res_valid and increment o_res_addr.
REQ-025 SHALL allow, when i_res_ready is high, the beat that starts the next word to be accepted in the same cycle as the pending word's handshake.
REQ-026 SHALL enter FLUSH after the last row byte is written, and leave FLUSH for DONE on the final word handshake.
REQ-027 SHALL assert o_done for exactly one cycle in DONE, then return to IDLE.
REQ-028 SHALL perform GF(2^8) addition as bitwise XOR only, with no carries and no width growth.
REQ-029 SHALL ignore i_valid outside ACCUM, so it has no effect on state.

Reset
REQ-030 SHALL, on i_rst low at any time including mid-row or with a word pending, immediately force IDLE, set all counters and acc to 0, and set o_res, o_res_addr, o_res_valid, o_ready, o_busy and o_done to 0.
REQ-031 SHALL, after reset release, require a new i_start before any beat is accepted.

Verification
REQ-032 SHALL cover defaults (8,8,8): i_start, then i_partial 0x01..0x08 on consecutive cycles with i_res_ready=1 -> o_res=0x0102030405060708, o_res_addr=0, o_done one cycle after the handshake.
REQ-033 SHALL cover MAT_COL_SIZE=16: beat pairs (0x0F,0xF0) repeated for 8 rows -> o_res=0xFFFFFFFFFFFFFFFF.
REQ-034 SHALL cover MAT_ROW_SIZE=10: rows 0x01..0x0A -> word0=0x0102030405060708 at addr 0, then word1=0x090A000000000000 at addr 1.
REQ-035 SHALL cover backpressure: i_res_ready=0 for 5 cycles with a word pending -> o_ready=0, o_res stable, no beats lost, and the word issues on i_res_ready=1.
REQ-036 SHALL cover reset mid-row: i_rst low after 3 beats -> all outputs 0 and IDLE; a subsequent full run matches REQ-032.
REQ-037 SHALL cover i_start asserted in ACCUM -> counters unaffected and the result identical to REQ-032.
